spi_reg_ctrl: RTL and testbench

- Command/register controller that sits behind the 8-bit SPI mode-3 slave and turns its byte stream into a simple register-bus protocol.
- The first byte of each CS frame is a command: bit7 = R/nW, bits[6:0] = start address.
- Subsequent bytes are written to consecutive registers, or read data is streamed back on MISO.
- Drives the slave's tx_data, and generates write/read strobes to the register bank.

---
 rtl/spi_reg_ctrl_if.sv | 14 +
 rtl/spi_reg_ctrl.sv | 115 +++++++++++
 tb/tb_spi_reg_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Register-bus side of the SPI command controller.
// The controller drives address, data and strobes; the register bank returns read data.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input  reg_rdata);
  modport slave  (input  reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/spi_reg_ctrl.sv
// Turns the SPI slave byte stream into register writes and prefetched register reads.
// The first byte of a CS frame is {R/nW, addr}; the following bytes are data.
module spi_reg_ctrl #(
  parameter int         ADDR_W   = 7,
  parameter logic [7:0] STATUS   = 8'hA5,
  parameter int         AUTO_INC = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           csn,
  input  logic [7:0]     rx_data,
  input  logic           rx_ready,
  output logic [7:0]     tx_data,
  output logic           busy,
  output logic           xfer_done,
  output logic [7:0]     byte_cnt,
  spi_reg_ctrl_if.master rbus
);
  typedef enum logic [2:0] {IDLE, CMD, RD_ISSUE, RD_CAP, READ, WRITE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        csn_sync;
  logic              csn_act, rdy_q, rdy_rise;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic [7:0]        cnt_inc;

  assign csn_act  = ~csn_sync[1];
  assign busy     = csn_act;
  assign rdy_rise = rx_ready & ~rdy_q & csn_act;
  assign addr_inc = addr + ADDR_W'(AUTO_INC != 0);
  assign cnt_inc  = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      csn_sync <= 2'b11;
      rdy_q    <= 1'b0;
    end else begin
      csn_sync <= {csn_sync[0], csn};
      rdy_q    <= rx_ready;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (!csn_act) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:     state_nxt = CMD;
        CMD:      if (rdy_rise) state_nxt = rx_data[7] ? RD_ISSUE : WRITE;
        RD_ISSUE: state_nxt = RD_CAP;
        RD_CAP:   state_nxt = READ;
        READ:     if (rdy_rise) state_nxt = RD_ISSUE;
        WRITE:    state_nxt = WRITE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Strobes are registered on the transition so reg_re is high while in RD_ISSUE
  // and reg_rdata is back in RD_CAP.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tx_data        <= STATUS;
      addr           <= '0;
      byte_cnt       <= 8'd0;
      xfer_done      <= 1'b0;
      rbus.reg_addr  <= '0;
      rbus.reg_wdata <= 8'd0;
      rbus.reg_we    <= 1'b0;
      rbus.reg_re    <= 1'b0;
    end else begin
      rbus.reg_we <= 1'b0;
      rbus.reg_re <= 1'b0;
      xfer_done   <= 1'b0;
      case (state)
        IDLE: begin
          tx_data <= STATUS;
          if (csn_act) byte_cnt <= 8'd0;
        end
        CMD: if (rdy_rise) begin
          addr     <= rx_data[ADDR_W-1:0];
          byte_cnt <= cnt_inc;
          if (rx_data[7]) begin
            rbus.reg_re   <= 1'b1;
            rbus.reg_addr <= rx_data[ADDR_W-1:0];
          end
        end
        RD_CAP: begin
          tx_data <= rbus.reg_rdata;
          addr    <= addr_inc;
        end
        READ: if (rdy_rise) begin
          byte_cnt      <= cnt_inc;
          rbus.reg_re   <= 1'b1;
          rbus.reg_addr <= addr;
        end
        WRITE: if (rdy_rise) begin
          byte_cnt       <= cnt_inc;
          rbus.reg_we    <= 1'b1;
          rbus.reg_addr  <= addr;
          rbus.reg_wdata <= rx_data;
          addr           <= addr_inc;
        end
        default: ;
      endcase
      // CS release wins over anything loaded above
      if (!csn_act) begin
        tx_data <= STATUS;
        if (state != IDLE && byte_cnt != 8'd0) xfer_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: byte-level SPI slave model plus a small register bank.
// A second instance with AUTO_INC=0 shares the stimulus for the fixed-address case.
module tb_spi_reg_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, csn = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data, byte_cnt, tx_ni, byte_cnt_ni;
  logic       busy, xfer_done, busy_ni, xfer_done_ni;
  logic [7:0] mem [128];
  logic [7:0] rdata = 8'h00;
  logic [15:0] wlog[$], wlog_ni[$];
  logic [6:0]  rlog[$];
  int total = 0, bad = 0;
  logic [7:0] miso, bc;
  int pulses;

  always #5 clk = ~clk;

  spi_reg_ctrl_if #(.ADDR_W(7)) bus();
  spi_reg_ctrl_if #(.ADDR_W(7)) bus_ni();
  assign bus.reg_rdata    = rdata;
  assign bus_ni.reg_rdata = 8'h00;

  spi_reg_ctrl #(.ADDR_W(7), .STATUS(8'hA5), .AUTO_INC(1)) u_dut (
    .clk(clk), .rstn(rstn), .csn(csn), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .busy(busy), .xfer_done(xfer_done), .byte_cnt(byte_cnt),
    .rbus(bus));

  spi_reg_ctrl #(.ADDR_W(7), .STATUS(8'hA5), .AUTO_INC(0)) u_dut_ni (
    .clk(clk), .rstn(rstn), .csn(csn), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_ni), .busy(busy_ni), .xfer_done(xfer_done_ni), .byte_cnt(byte_cnt_ni),
    .rbus(bus_ni));

  // register bank: one entry per strobe cycle, read data one clk after reg_re
  always @(posedge clk) begin
    if (bus.reg_we) wlog.push_back({1'b0, bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) begin
      rlog.push_back(bus.reg_addr);
      rdata <= mem[bus.reg_addr];
    end
    if (bus_ni.reg_we) wlog_ni.push_back({1'b0, bus_ni.reg_addr, bus_ni.reg_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wlog.delete(); wlog_ni.delete(); rlog.delete();
  endtask

  task automatic cs_low();
    @(negedge clk); csn = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // one byte: MISO byte is what tx_data holds when the byte starts
  task automatic send_byte(input logic [7:0] b, input bit hold, output logic [7:0] m);
    @(negedge clk); m = tx_data; rx_data = b; rx_ready = 1'b0;
    repeat (6) @(negedge clk); rx_ready = 1'b1;
    repeat (12) @(negedge clk); if (!hold) rx_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high(output int p, output logic [7:0] c);
    p = 0; c = 8'h00;
    @(negedge clk); csn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (xfer_done) begin p++; c = byte_cnt; end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[16] = 8'hC1; mem[17] = 8'hC2; mem[18] = 8'hC3;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_data, 8'hA5);
    chk("rst_addr", bus.reg_addr, 7'h00);
    chk("rst_wdata", bus.reg_wdata, 8'h00);
    chk("rst_strobes", {bus.reg_we, bus.reg_re}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", xfer_done, 1'b0);
    chk("rst_cnt", byte_cnt, 8'h00);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // write burst
    clear_logs();
    cs_low();
    chk("wr_busy", busy, 1'b1);
    send_byte(8'h05, 0, miso); chk("wr_miso0", miso, 8'hA5);
    send_byte(8'h11, 0, miso); chk("wr_miso1", miso, 8'hA5);
    send_byte(8'h22, 0, miso); chk("wr_miso2", miso, 8'hA5);
    send_byte(8'h33, 0, miso); chk("wr_miso3", miso, 8'hA5);
    chk("wr_tx_end", tx_data, 8'hA5);
    cs_high(pulses, bc);
    chk("wr_done", pulses, 1);
    chk("wr_cnt", bc, 8'd4);
    chk("wr_n", wlog.size(), 3);
    chk("wr_0", wlog[0], 16'h0511);
    chk("wr_1", wlog[1], 16'h0622);
    chk("wr_2", wlog[2], 16'h0733);
    chk("wr_noread", rlog.size(), 0);
    chk("wr_busy_off", busy, 1'b0);

    // read burst with prefetch
    clear_logs();
    cs_low();
    send_byte(8'h90, 0, miso); chk("rd_miso0", miso, 8'hA5);
    send_byte(8'h00, 0, miso); chk("rd_miso1", miso, 8'hC1);
    send_byte(8'h00, 0, miso); chk("rd_miso2", miso, 8'hC2);
    send_byte(8'h00, 0, miso); chk("rd_miso3", miso, 8'hC3);
    cs_high(pulses, bc);
    chk("rd_done", pulses, 1);
    chk("rd_cnt", bc, 8'd4);
    chk("rd_tx_idle", tx_data, 8'hA5);
    chk("rd_n", rlog.size(), 4);
    chk("rd_a0", rlog[0], 7'h10);
    chk("rd_a1", rlog[1], 7'h11);
    chk("rd_a2", rlog[2], 7'h12);
    chk("rd_a3", rlog[3], 7'h13);
    chk("rd_nowrite", wlog.size(), 0);

    // address wrap, and fixed address when auto-increment is off
    clear_logs();
    cs_low();
    send_byte(8'h7F, 0, miso);
    send_byte(8'hAA, 0, miso);
    send_byte(8'hBB, 0, miso);
    cs_high(pulses, bc);
    chk("wrap_n", wlog.size(), 2);
    chk("wrap_0", wlog[0], 16'h7FAA);
    chk("wrap_1", wlog[1], 16'h00BB);
    chk("ninc_n", wlog_ni.size(), 2);
    chk("ninc_0", wlog_ni[0], 16'h7FAA);
    chk("ninc_1", wlog_ni[1], 16'h7FBB);

    // empty frame: no xfer_done
    cs_low();
    cs_high(pulses, bc);
    chk("empty_done", pulses, 0);

    // abort mid second byte
    clear_logs();
    cs_low();
    send_byte(8'h03, 0, miso);
    @(negedge clk); rx_data = 8'h44;
    repeat (24) @(negedge clk);
    cs_high(pulses, bc);
    chk("abort_nowrite", wlog.size(), 0);
    chk("abort_done", pulses, 1);
    chk("abort_cnt", bc, 8'd1);
    cs_low();
    chk("abort_cnt_clr", byte_cnt, 8'd0);
    send_byte(8'h20, 0, miso);
    send_byte(8'h55, 0, miso);
    cs_high(pulses, bc);
    chk("abort_next_n", wlog.size(), 1);
    chk("abort_next", wlog[0], 16'h2055);

    // back-to-back frames, rx_ready stale high across the CS gap
    clear_logs();
    cs_low();
    send_byte(8'h08, 0, miso);
    send_byte(8'h66, 1, miso);
    cs_high(pulses, bc);
    chk("b2b_cnt1", bc, 8'd2);
    cs_low();
    repeat (10) @(negedge clk);
    chk("b2b_nobyte", byte_cnt, 8'd0);
    send_byte(8'h0A, 0, miso);
    send_byte(8'h77, 0, miso);
    cs_high(pulses, bc);
    chk("b2b_cnt2", bc, 8'd2);
    chk("b2b_n", wlog.size(), 2);
    chk("b2b_0", wlog[0], 16'h0866);
    chk("b2b_1", wlog[1], 16'h0A77);

    // async reset mid-read
    cs_low();
    send_byte(8'h90, 0, miso);
    chk("rr_tx_loaded", tx_data, 8'hC1);
    @(negedge clk); rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rr_tx", tx_data, 8'hA5);
    chk("rr_strobes", {bus.reg_we, bus.reg_re}, 2'b00);
    chk("rr_busy", busy, 1'b0);
    chk("rr_cnt", byte_cnt, 8'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
    send_byte(8'h30, 0, miso);
    send_byte(8'h99, 0, miso);
    cs_high(pulses, bc);
    chk("rr_next_done", pulses, 1);
    chk("rr_next_cnt", bc, 8'd2);
    chk("rr_next_n", wlog.size(), 1);
    chk("rr_next_wr", wlog[0], 16'h3099);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
